demux1x2_stream: RTL and testbench

- Sequential 1-to-2 demultiplexer; the inverse of the datapath's 2:1 select.
- One input stream is steered by a per-word select bit into one of two output streams.
- Each output has its own small FIFO, so a stalled consumer does not block words bound for the other output once they are queued.
- Sits between a producer and two downstream datapath consumers. All handshakes are valid/ready.

---
 rtl/demux1x2_stream.sv | 123 ++++++++++++
 tb/tb_demux1x2_stream.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_stream.sv
// ---------------------------------------------------------------------------
// demux1x2_stream
//
// Routes one valid/ready input stream to one of two output streams. Each
// input word carries its own select bit. Each output has a private FIFO, so a
// stalled consumer only blocks new words that are bound for its own output.
//
// Parameters:
//   n      data width in bits (default 32)
//   DEPTH  entries per output FIFO; a power of 2, at least 2 (default 2)
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        producer handshake
//   in_sel                   destination of the presented word (0=out0, 1=out1)
//   in_data                  word to route
//   out0_valid/out0_ready    consumer 0 handshake; out0_data is the FIFO head
//   out1_valid/out1_ready    consumer 1 handshake; out1_data is the FIFO head
//   flush                    synchronous discard of every queued word
//   cnt0, cnt1               (only with DEMUX1X2_STATS_EN) 16-bit wrapping
//                            counts of pushes accepted for out0 and out1
//
// Optional feature macro: DEMUX1X2_STATS_EN
//
// Handshake: a transfer happens at a rising edge on which valid && ready.
// A producer holds data and select stable while valid=1 and ready=0.
// in_ready is a function of in_sel, FIFO state, rst and flush only. It never
// depends on outX_ready, so no combinational path runs from ready to ready.
// ---------------------------------------------------------------------------
module demux1x2_stream #(
    parameter int n     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [n-1:0] in_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [n-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [n-1:0] out1_data,
`ifdef DEMUX1X2_STATS_EN
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1,
`endif
    input  logic         flush
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]   full;
    logic [1:0]   empty;
    logic [1:0]   pop;
    logic [1:0]   out_ready;
    logic [n-1:0] head [2];
    logic         push;

    assign out_ready = {out1_ready, out0_ready};

    // Only the FIFO addressed by in_sel gates acceptance. A pop in the same
    // cycle does not free a slot early.
    assign in_ready = !full[in_sel] && !rst && !flush;
    assign push     = in_valid && in_ready;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [AW:0]  wptr;
        logic [AW:0]  rptr;
        logic [n-1:0] mem [DEPTH];
        logic         do_push;

        assign do_push  = push && (in_sel == 1'(g));

        // The extra pointer MSB tells full apart from empty when the
        // address bits match.
        assign empty[g] = (wptr == rptr);
        assign full[g]  = (wptr[AW] != rptr[AW]) &&
                          (wptr[AW-1:0] == rptr[AW-1:0]);
        assign pop[g]   = !empty[g] && out_ready[g];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + PTR_ONE;
                if (pop[g])  rptr <= rptr + PTR_ONE;
            end
        end

        // Storage is not reset. Its contents do not matter while the FIFO
        // is empty, because the head is masked to zero then.
        always_ff @(posedge clk) begin
            if (do_push) mem[wptr[AW-1:0]] <= in_data;
        end

        assign head[g] = empty[g] ? '0 : mem[rptr[AW-1:0]];
    end

    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];
    assign out0_data  = head[0];
    assign out1_data  = head[1];

`ifdef DEMUX1X2_STATS_EN
    // Only rst clears the counters. A flush discards queued words but
    // leaves the statistics for pushes already accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (push) begin
            if (in_sel) cnt1 <= cnt1 + 16'd1;
            else        cnt0 <= cnt0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// ---------------------------------------------------------------------------
// Testbench for demux1x2_stream. The reference model is two queues, one per
// output. Each queue holds at most DEPTH words, and rst or flush clears both.
// ---------------------------------------------------------------------------
module tb_demux1x2_stream;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sel = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out0_valid;
    logic         out0_ready = 1'b0;
    logic [W-1:0] out0_data;
    logic         out1_valid;
    logic         out1_ready = 1'b0;
    logic [W-1:0] out1_data;
    logic         flush = 1'b0;
`ifdef DEMUX1X2_STATS_EN
    logic [15:0]  cnt0;
    logic [15:0]  cnt1;
`endif

    demux1x2_stream #(.n(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
`ifdef DEMUX1X2_STATS_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .flush      (flush)
    );

    // scoreboard: expected queues and counters
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [15:0]  exp_cnt0 = '0;
    logic [15:0]  exp_cnt1 = '0;
    logic         last_stalled = 1'b0;
    int           checks = 0;
    int           errors = 0;

    // This task advances one edge and updates the model from the inputs
    // presented at that edge.
    task automatic tick();
        logic acc, p0, p1;
        int   room;
        room = in_sel ? exp_q1.size() : exp_q0.size();
        acc  = in_valid && !rst && !flush && (room < DEPTH);
        p0   = out0_ready && (exp_q0.size() > 0);
        p1   = out1_ready && (exp_q1.size() > 0);
        last_stalled = in_valid && !acc;
        @(posedge clk);
        if (rst || flush) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (p0) void'(exp_q0.pop_front());
            if (p1) void'(exp_q1.pop_front());
            if (acc) begin
                if (in_sel) exp_q1.push_back(in_data);
                else        exp_q0.push_back(in_data);
            end
        end
        if (rst) begin
            exp_cnt0 = '0;
            exp_cnt1 = '0;
        end else if (acc) begin
            if (in_sel) exp_cnt1 = exp_cnt1 + 16'd1;
            else        exp_cnt0 = exp_cnt0 + 16'd1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        in_sel = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low got %0b want 0", in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b%0b want 00", out0_valid, out1_valid);
        end
        checks++;
        if (out0_data !== '0 || out1_data !== '0) begin
            errors++; $display("FAIL reset_data got %h %h want 0 0", out0_data, out1_data);
        end
        in_sel = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_sel0 got %0b want 1", in_ready);
        end
        in_sel = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_sel1 got %0b want 1", in_ready);
        end
    endtask

    task automatic test_single_route();
        do_flush();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL route_in_ready got %0b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL route_out1 got %0b/%h want 1/deadbeef", out1_valid, out1_data);
        end
        checks++;
        if (out0_valid !== 1'b0) begin
            errors++; $display("FAIL route_out0_idle got %0b want 0", out0_valid);
        end
    endtask

    task automatic test_full_backpressure();
        do_flush();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1; tick();
        in_data = 32'h2; tick();
        in_data = 32'h3; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready_sel0 got %0b want 0", in_ready);
        end
        in_valid = 1'b0; in_sel = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_ready_sel1 got %0b want 1", in_ready);
        end
        // A pop in this cycle does not open the full FIFO in the same cycle.
        in_valid = 1'b1; in_sel = 1'b0; out0_ready = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b0 || out0_data !== 32'h1) begin
            errors++; $display("FAIL full_pop_same_cycle got %0b/%h want 0/1", in_ready, out0_data);
        end
        tick();
        out0_ready = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_after_pop got %0b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0; out0_ready = 1'b1; #1;
        checks++;
        if (out0_data !== 32'h2) begin
            errors++; $display("FAIL drain_first got %h want 2", out0_data);
        end
        tick();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h3) begin
            errors++; $display("FAIL drain_second got %0b/%h want 1/3", out0_valid, out0_data);
        end
        tick();
        checks++;
        if (out0_valid !== 1'b0 || out0_data !== '0) begin
            errors++; $display("FAIL drain_empty got %0b/%h want 0/0", out0_valid, out0_data);
        end
        out0_ready = 1'b0;
    endtask

    task automatic test_concurrent();
        do_flush();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h77; tick();
        in_data = 32'hA; out1_ready = 1'b1; #1;
        checks++;
        if (out1_data !== 32'h77 || in_ready !== 1'b1) begin
            errors++; $display("FAIL conc_before got %h/%0b want 77/1", out1_data, in_ready);
        end
        tick();
        in_valid = 1'b0; #1;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hA || exp_q1.size() != 1) begin
            errors++; $display("FAIL conc_after got %0b/%h want 1/a", out1_valid, out1_data);
        end
        tick();
        checks++;
        if (out1_valid !== 1'b0) begin
            errors++; $display("FAIL conc_drain got %0b want 0", out1_valid);
        end
        out1_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_flush();
        in_valid = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            in_sel  = (i >= DEPTH);
            in_data = 32'h100 + i;
            tick();
        end
        flush = 1'b1; in_sel = 1'b0; in_data = 32'h99; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready got %0b want 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid got %0b%0b want 00", out0_valid, out1_valid);
        end
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55; tick();
        in_valid = 1'b0; #1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h55 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL flush_repush got %0b/%h/%0b want 1/55/0", out0_valid, out0_data, out1_valid);
        end
        out0_ready = 1'b1; tick();
        checks++;
        if (out0_valid !== 1'b0) begin
            errors++; $display("FAIL flush_repush_alone got %0b want 0", out0_valid);
        end
        out0_ready = 1'b0;
    endtask

    task automatic test_random();
        logic         exp_ready;
        logic [W-1:0] e0, e1;
        do_flush();
        last_stalled = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!last_stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out0_ready = ($urandom_range(0, 2) == 0);
            out1_ready = ($urandom_range(0, 1) == 0);
            flush      = ($urandom_range(0, 39) == 0);
            #1;
            exp_ready = !flush && ((in_sel ? exp_q1.size() : exp_q0.size()) < DEPTH);
            e0 = (exp_q0.size() > 0) ? exp_q0[0] : '0;
            e1 = (exp_q1.size() > 0) ? exp_q1[0] : '0;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL rand_in_ready cyc %0d got %0b want %0b", c, in_ready, exp_ready);
            end
            checks++;
            if (out0_valid !== (exp_q0.size() > 0) || out0_data !== e0) begin
                errors++; $display("FAIL rand_out0 cyc %0d got %0b/%h want %0b/%h", c, out0_valid, out0_data, exp_q0.size() > 0, e0);
            end
            checks++;
            if (out1_valid !== (exp_q1.size() > 0) || out1_data !== e1) begin
                errors++; $display("FAIL rand_out1 cyc %0d got %0b/%h want %0b/%h", c, out1_valid, out1_data, exp_q1.size() > 0, e1);
            end
            tick();
        end
        idle_inputs();
    endtask

`ifdef DEMUX1X2_STATS_EN
    task automatic test_stats();
        idle_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; out0_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_data = i;
            tick();
        end
        idle_inputs(); #1;
        checks++;
        if (cnt0 !== 16'h0001 || cnt1 !== 16'h0000 || exp_cnt0 !== 16'h0001) begin
            errors++; $display("FAIL stats_wrap got %h/%h want 0001/0000", cnt0, cnt1);
        end
        do_flush();
        checks++;
        if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin
            errors++; $display("FAIL stats_flush got %h/%h want %h/%h", cnt0, cnt1, exp_cnt0, exp_cnt1);
        end
    endtask
`endif

    // watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_route();
        test_full_backpressure();
        test_concurrent();
        test_flush();
        test_random();
`ifdef DEMUX1X2_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
